// File: rtl/alu_control_mdu_pkg.sv
// Shared encodings for the ALU control decoder and its iterative multiply/divide unit.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SLL  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SRA  = 4'b0111;
  localparam logic [3:0] ALU_SLT  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;

  localparam logic [1:0] ALUOP_MEM = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

  localparam logic [2:0] F3_MUL   = 3'b000;
  localparam logic [2:0] F3_MULHU = 3'b011;
  localparam logic [2:0] F3_DIVU  = 3'b101;
  localparam logic [2:0] F3_REMU  = 3'b111;

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} mdu_state_e;
  typedef enum logic [1:0] {MOP_MUL, MOP_MULHU, MOP_DIVU, MOP_REMU} mop_e;

endpackage

// File: rtl/alu_control_mdu_if.sv
// Control/operand bundle between main control, the datapath and alu_control_mdu.
interface alu_control_mdu_if #(parameter int XLEN = 64);
  logic [1:0]      ALUOp;
  logic [4:0]      Funct;
  logic            op_valid;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic [3:0]      Operation;
  logic            illegal;
  logic            stall;
  logic            mdu_done;
  logic [XLEN-1:0] mdu_result;

  modport master (output ALUOp, Funct, op_valid, a, b,
                  input  Operation, illegal, stall, mdu_done, mdu_result);
  modport slave  (input  ALUOp, Funct, op_valid, a, b,
                  output Operation, illegal, stall, mdu_done, mdu_result);
endinterface

// File: rtl/alu_control_mdu_iter.sv
// Iterative radix-2 MDU: shift-add multiply and restoring divide, one bit per cycle.
module alu_control_mdu_iter
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_start,
  input  mop_e            i_op,
  input  logic [XLEN-1:0] i_a,
  input  logic [XLEN-1:0] i_b,
  output logic            o_idle,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);
  localparam int CNT_W = $clog2(XLEN + 1);

  mdu_state_e      r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  mop_e            r_op;
  logic [XLEN-1:0] r_b, r_hi, r_lo;
  logic            w_last, w_is_div;
  logic [XLEN:0]   w_sum, w_shl, w_diff;

  assign w_last = (r_cnt == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_idle      = 1'b0;
    o_busy      = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_idle = 1'b1;
        if (i_start) w_state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        o_busy = 1'b1;
        if (w_last) w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // {r_hi,r_lo} is the 2*XLEN accumulator: product for multiply, {remainder,quotient} for divide.
  assign w_is_div = (r_op == MOP_DIVU) || (r_op == MOP_REMU);
  assign w_sum    = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : '0);
  assign w_shl    = {r_hi, r_lo[XLEN-1]};
  assign w_diff   = w_shl - {1'b0, r_b};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
      r_op  <= MOP_MUL;
      r_b   <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else if (o_idle && i_start) begin
      r_cnt <= '0;
      r_op  <= i_op;
      r_b   <= i_b;
      r_hi  <= '0;
      r_lo  <= i_a;
    end else if (o_busy) begin
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_is_div) begin
        // Borrow-free subtract sets the quotient bit; a zero divisor never borrows,
        // which yields all-ones quotient and remainder = a.
        if (!w_diff[XLEN]) begin
          r_hi <= w_diff[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b1};
        end else begin
          r_hi <= w_shl[XLEN-1:0];
          r_lo <= {r_lo[XLEN-2:0], 1'b0};
        end
      end else begin
        r_hi <= w_sum[XLEN:1];
        r_lo <= {w_sum[0], r_lo[XLEN-1:1]};
      end
    end
  end

  assign o_result = (r_op == MOP_MULHU || r_op == MOP_REMU) ? r_hi : r_lo;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decoder with an attached M-extension sequencer; stalls the PC during multi-cycle ops.
module alu_control_mdu
  import alu_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit ENABLE_M = 1'b1
) (
  input logic               clk,
  input logic               reset,
  alu_control_mdu_if.slave  bus
);
  logic [3:0] w_op;
  logic       w_illegal, w_is_m, w_start;
  logic       w_idle, w_busy, w_done;
  mop_e       w_mop;
  logic [2:0] w_f3;
  logic       w_alt;

  assign w_f3  = bus.Funct[2:0];
  assign w_alt = bus.Funct[4];

  always_comb begin
    w_op      = ALU_ADD;
    w_illegal = 1'b0;
    w_is_m    = 1'b0;
    w_mop     = MOP_MUL;
    case (bus.ALUOp)
      ALUOP_MEM: w_op = ALU_ADD;
      ALUOP_BR:  w_op = ALU_SUB;
      ALUOP_R: begin
        if (bus.Funct[3]) begin
          // M ops keep ALU_ADD on Operation; the datapath takes mdu_result instead.
          case (w_f3)
            F3_MUL:   begin w_is_m = 1'b1; w_mop = MOP_MUL;   end
            F3_MULHU: begin w_is_m = 1'b1; w_mop = MOP_MULHU; end
            F3_DIVU:  begin w_is_m = 1'b1; w_mop = MOP_DIVU;  end
            F3_REMU:  begin w_is_m = 1'b1; w_mop = MOP_REMU;  end
            default:  w_illegal = 1'b1;
          endcase
          if (!ENABLE_M) begin
            w_is_m    = 1'b0;
            w_illegal = 1'b1;
          end
        end else begin
          case ({w_alt, w_f3})
            4'b0_000: w_op = ALU_ADD;
            4'b1_000: w_op = ALU_SUB;
            4'b0_111: w_op = ALU_AND;
            4'b0_110: w_op = ALU_OR;
            4'b0_100: w_op = ALU_XOR;
            4'b0_001: w_op = ALU_SLL;
            4'b0_101: w_op = ALU_SRL;
            4'b1_101: w_op = ALU_SRA;
            4'b0_010: w_op = ALU_SLT;
            4'b0_011: w_op = ALU_SLTU;
            default:  w_illegal = 1'b1;
          endcase
        end
      end
      ALUOP_I: begin
        case (w_f3)
          3'b000: w_op = ALU_ADD;
          3'b111: w_op = ALU_AND;
          3'b110: w_op = ALU_OR;
          3'b100: w_op = ALU_XOR;
          3'b001: w_op = ALU_SLL;
          3'b101: w_op = w_alt ? ALU_SRA : ALU_SRL;
          3'b010: w_op = ALU_SLT;
          3'b011: w_op = ALU_SLTU;
          default: w_op = ALU_ADD;
        endcase
      end
      default: w_op = ALU_ADD;
    endcase
  end

  assign w_start = bus.op_valid & w_is_m & ~reset;

  alu_control_mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk      (clk),
    .reset    (reset),
    .i_start  (w_start),
    .i_op     (w_mop),
    .i_a      (bus.a),
    .i_b      (bus.b),
    .o_idle   (w_idle),
    .o_busy   (w_busy),
    .o_done   (w_done),
    .o_result (bus.mdu_result)
  );

  // Stall rises in the start cycle itself so the PC never advances past an M op.
  assign bus.stall     = (w_idle & w_start) | w_busy;
  assign bus.Operation = w_op;
  assign bus.illegal   = w_illegal;
  assign bus.mdu_done  = w_done;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Bench for alu_control_mdu: decode tables, M-op latency/results and reset/back-to-back corners.
module tb_alu_control_mdu;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_control_mdu_if #(.XLEN(64)) if0 ();
  alu_control_mdu_if #(.XLEN(8))  if1 ();
  alu_control_mdu_if #(.XLEN(8))  if2 ();

  alu_control_mdu #(.XLEN(64), .ENABLE_M(1'b1)) dut0 (.clk(clk), .reset(rst), .bus(if0.slave));
  alu_control_mdu #(.XLEN(8),  .ENABLE_M(1'b1)) dut1 (.clk(clk), .reset(rst), .bus(if1.slave));
  alu_control_mdu #(.XLEN(8),  .ENABLE_M(1'b0)) dut2 (.clk(clk), .reset(rst), .bus(if2.slave));

  logic [1:0]  d_aop [3];
  logic [4:0]  d_fn  [3];
  logic        d_vld [3];
  logic [63:0] d_a   [3];
  logic [63:0] d_b   [3];
  logic [3:0]  ob_op   [3];
  logic        ob_ill  [3];
  logic        ob_stall[3];
  logic        ob_done [3];
  logic [63:0] ob_res  [3];

  assign if0.ALUOp = d_aop[0]; assign if0.Funct = d_fn[0]; assign if0.op_valid = d_vld[0];
  assign if0.a = d_a[0];       assign if0.b = d_b[0];
  assign if1.ALUOp = d_aop[1]; assign if1.Funct = d_fn[1]; assign if1.op_valid = d_vld[1];
  assign if1.a = d_a[1][7:0];  assign if1.b = d_b[1][7:0];
  assign if2.ALUOp = d_aop[2]; assign if2.Funct = d_fn[2]; assign if2.op_valid = d_vld[2];
  assign if2.a = d_a[2][7:0];  assign if2.b = d_b[2][7:0];

  assign ob_op[0] = if0.Operation; assign ob_ill[0] = if0.illegal; assign ob_stall[0] = if0.stall;
  assign ob_done[0] = if0.mdu_done; assign ob_res[0] = if0.mdu_result;
  assign ob_op[1] = if1.Operation; assign ob_ill[1] = if1.illegal; assign ob_stall[1] = if1.stall;
  assign ob_done[1] = if1.mdu_done; assign ob_res[1] = {56'b0, if1.mdu_result};
  assign ob_op[2] = if2.Operation; assign ob_ill[2] = if2.illegal; assign ob_stall[2] = if2.stall;
  assign ob_done[2] = if2.mdu_done; assign ob_res[2] = {56'b0, if2.mdu_result};

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input int s, input logic [1:0] aop, input logic [4:0] fn, input logic v,
                       input logic [63:0] a, input logic [63:0] b);
    d_aop[s] = aop; d_fn[s] = fn; d_vld[s] = v; d_a[s] = a; d_b[s] = b;
  endtask

  // Decode reference built from the instruction tables: base op by funct3, alternates by funct7[5].
  function automatic void ref_dec(input logic [1:0] aop, input logic [4:0] fn, input bit en,
                                  output logic [3:0] op, output logic ill);
    logic [3:0] tbl [8];
    tbl = '{4'b0010, 4'b0100, 4'b1000, 4'b1001, 4'b0011, 4'b0101, 4'b0001, 4'b0000};
    op = 4'b0010; ill = 1'b0;
    case (aop)
      2'd1: op = 4'b0110;
      2'd3: begin
        op = tbl[fn[2:0]];
        if (fn[2:0] == 3'd5 && fn[4]) op = 4'b0111;
      end
      2'd2: begin
        if (fn[3])                        ill = !(en && (fn[2:0] inside {3'd0, 3'd3, 3'd5, 3'd7}));
        else if (fn[4] && fn[2:0] == 3'd0) op = 4'b0110;
        else if (fn[4] && fn[2:0] == 3'd5) op = 4'b0111;
        else if (fn[4])                   ill = 1'b1;
        else                              op = tbl[fn[2:0]];
      end
      default: op = 4'b0010;
    endcase
  endfunction

  function automatic logic [63:0] ref_mdu(input logic [2:0] f3, input logic [63:0] a,
                                          input logic [63:0] b, input int xl);
    logic [63:0]  m;
    logic [127:0] p;
    m = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << xl) - 64'd1);
    a = a & m; b = b & m;
    p = {64'b0, a} * {64'b0, b};
    case (f3)
      3'd0:    return p[63:0] & m;
      3'd3:    return (p >> xl) & {64'b0, m};
      3'd5:    return (b == 0) ? m : a / b;
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Issue one M op, hold op_valid until the done pulse, then check latency, stall and result.
  task automatic run_op(input int s, input logic [2:0] f3, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input string nm);
    int xl, k;
    bit seen, held;
    xl = (s == 0) ? 64 : 8;
    @(posedge clk); #1;
    drive(s, 2'b10, {2'b01, f3}, 1'b1, a, b);
    #1;
    chk({nm, "/start_stall"}, {63'b0, ob_stall[s]}, 64'd1);
    k = 0; seen = 0; held = 1;
    while (!seen && k < xl + 8) begin
      @(posedge clk); #2;
      k++;
      if (ob_done[s]) seen = 1;
      else if (!ob_stall[s]) held = 0;
    end
    chk({nm, "/latency"}, 64'(k), 64'(xl + 1));
    chk({nm, "/busy_stall"}, {63'b0, held}, 64'd1);
    chk({nm, "/done_stall"}, {63'b0, ob_stall[s]}, 64'd0);
    chk({nm, "/result"}, ob_res[s], exp);
    drive(s, 2'b00, 5'b0, 1'b0, 64'b0, 64'b0);
  endtask

  typedef struct {
    logic [1:0] aop;
    logic [4:0] fn;
    logic [3:0] op;
    logic       ill;
  } dvec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
  } mvec_t;

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation still running, required finish");
    $fatal(1);
  end

  initial begin
    dvec_t dv[14];
    mvec_t mv[6];
    logic [2:0] mf3 [4];
    logic [3:0] rop;
    logic rill;
    int ndone, d1, d2;
    logic st65, st66;
    logic [63:0] r1, r2, ra, rb;

    dv = '{'{2'b10, 5'b10101, 4'b0111, 1'b0}, '{2'b10, 5'b00001, 4'b0100, 1'b0},
           '{2'b11, 5'b10000, 4'b0010, 1'b0}, '{2'b00, 5'b11111, 4'b0010, 1'b0},
           '{2'b01, 5'b01010, 4'b0110, 1'b0}, '{2'b10, 5'b10111, 4'b0010, 1'b1},
           '{2'b10, 5'b01000, 4'b0010, 1'b0}, '{2'b10, 5'b01001, 4'b0010, 1'b1},
           '{2'b11, 5'b11101, 4'b0111, 1'b0}, '{2'b11, 5'b00101, 4'b0101, 1'b0},
           '{2'b10, 5'b00011, 4'b1001, 1'b0}, '{2'b10, 5'b10000, 4'b0110, 1'b0},
           '{2'b11, 5'b10010, 4'b1000, 1'b0}, '{2'b10, 5'b00110, 4'b0001, 1'b0}};
    mv = '{'{3'd0, 64'd7, 64'd6, 64'd42},
           '{3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'd1},
           '{3'd5, 64'd100, 64'd7, 64'd14},
           '{3'd7, 64'd100, 64'd7, 64'd2},
           '{3'd5, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF},
           '{3'd7, 64'h1234, 64'd0, 64'h1234}};
    mf3 = '{3'd0, 3'd3, 3'd5, 3'd7};

    rst = 1'b1;
    for (int s = 0; s < 3; s++) drive(s, 2'b00, 5'b0, 1'b0, 64'b0, 64'b0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      chk($sformatf("reset/stall%0d", s),  {63'b0, ob_stall[s]}, 64'd0);
      chk($sformatf("reset/done%0d", s),   {63'b0, ob_done[s]},  64'd0);
      chk($sformatf("reset/result%0d", s), ob_res[s], 64'd0);
    end
    rst = 1'b0;

    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      drive(0, dv[i].aop, dv[i].fn, 1'b0, 64'b0, 64'b0);
      #1;
      chk($sformatf("dtab%0d/op", i),    {60'b0, ob_op[0]}, {60'b0, dv[i].op});
      chk($sformatf("dtab%0d/ill", i),   {63'b0, ob_ill[0]}, {63'b0, dv[i].ill});
      chk($sformatf("dtab%0d/stall", i), {63'b0, ob_stall[0]}, 64'd0);
    end

    for (int v = 0; v < 128; v++) begin
      @(negedge clk);
      for (int s = 0; s < 3; s++) drive(s, v[6:5], v[4:0], 1'b0, 64'b0, 64'b0);
      #1;
      for (int s = 0; s < 3; s++) begin
        ref_dec(v[6:5], v[4:0], s != 2, rop, rill);
        chk($sformatf("sweep%0d/aop%0d/fn%0h/op", s, v[6:5], v[4:0]),  {60'b0, ob_op[s]}, {60'b0, rop});
        chk($sformatf("sweep%0d/aop%0d/fn%0h/ill", s, v[6:5], v[4:0]), {63'b0, ob_ill[s]}, {63'b0, rill});
      end
    end

    // M ops with the unit disabled, and an unsupported M funct3 with it enabled: never start.
    for (int j = 0; j < 4; j++) begin
      @(posedge clk); #1;
      drive(2, 2'b10, {2'b01, mf3[j]}, 1'b1, 64'd9, 64'd3);
      for (int c = 0; c < 3; c++) begin
        #1;
        chk($sformatf("noM/f3_%0d/c%0d/stall", mf3[j], c), {63'b0, ob_stall[2]}, 64'd0);
        chk($sformatf("noM/f3_%0d/c%0d/ill", mf3[j], c),   {63'b0, ob_ill[2]},   64'd1);
        chk($sformatf("noM/f3_%0d/c%0d/done", mf3[j], c),  {63'b0, ob_done[2]},  64'd0);
        @(posedge clk); #1;
      end
      drive(2, 2'b00, 5'b0, 1'b0, 64'b0, 64'b0);
    end
    @(posedge clk); #1;
    drive(0, 2'b10, 5'b01001, 1'b1, 64'd5, 64'd5);
    repeat (2) begin
      #1;
      chk("badM/stall", {63'b0, ob_stall[0]}, 64'd0);
      @(posedge clk); #1;
    end
    drive(0, 2'b00, 5'b0, 1'b0, 64'b0, 64'b0);

    for (int i = 0; i < 6; i++) begin
      run_op(0, mv[i].f3, mv[i].a, mv[i].b, mv[i].exp, $sformatf("mtab64_%0d", i));
      run_op(1, mv[i].f3, mv[i].a, mv[i].b, ref_mdu(mv[i].f3, mv[i].a, mv[i].b, 8),
             $sformatf("mtab8_%0d", i));
    end

    // Reset in the 10th BUSY cycle aborts the op; a fresh MUL then runs at full latency.
    @(posedge clk); #1;
    drive(0, 2'b10, {2'b01, 3'd0}, 1'b1, 64'd9, 64'd9);
    repeat (10) @(posedge clk);
    #2;
    chk("rstmid/busy_stall", {63'b0, ob_stall[0]}, 64'd1);
    rst = 1'b1;
    drive(0, 2'b00, 5'b0, 1'b0, 64'b0, 64'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstmid/stall",  {63'b0, ob_stall[0]}, 64'd0);
    chk("rstmid/done",   {63'b0, ob_done[0]},  64'd0);
    chk("rstmid/result", ob_res[0], 64'd0);
    @(posedge clk); #2;
    chk("rstmid/idle_stall", {63'b0, ob_stall[0]}, 64'd0);
    run_op(0, 3'd0, 64'd3, 64'd5, 64'd15, "rstmid_mul");

    // MUL then DIVU with op_valid held across the done cycle.
    @(posedge clk); #1;
    drive(0, 2'b10, {2'b01, 3'd0}, 1'b1, 64'd123456789, 64'd1000);
    ndone = 0; d1 = -1; d2 = -1; st65 = 1'bx; st66 = 1'bx; r1 = '0; r2 = '0;
    for (int c = 0; c < 150 && ndone < 2; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      #1;
      if (c == 65) st65 = ob_stall[0];
      if (c == 66) st66 = ob_stall[0];
      if (ob_done[0]) begin
        ndone++;
        if (ndone == 1) begin
          d1 = c; r1 = ob_res[0];
          drive(0, 2'b10, {2'b01, 3'd5}, 1'b1, 64'd1000000, 64'd3);
        end else begin
          d2 = c; r2 = ob_res[0];
          drive(0, 2'b00, 5'b0, 1'b0, 64'b0, 64'b0);
        end
      end
    end
    chk("b2b/ndone",      64'(ndone), 64'd2);
    chk("b2b/done1_cyc",  64'(d1), 64'd65);
    chk("b2b/done2_cyc",  64'(d2), 64'd131);
    chk("b2b/stall65",    {63'b0, st65}, 64'd0);
    chk("b2b/stall66",    {63'b0, st66}, 64'd1);
    chk("b2b/mul_res",    r1, 64'd123456789000);
    chk("b2b/divu_res",   r2, 64'd333333);
    repeat (2) begin
      @(posedge clk); #2;
      chk("b2b/after_stall", {63'b0, ob_stall[0]}, 64'd0);
      chk("b2b/after_done",  {63'b0, ob_done[0]},  64'd0);
    end

    for (int i = 0; i < 24; i++) begin
      int s, sel;
      logic [2:0] f3;
      s = i % 2;
      f3 = mf3[$urandom_range(0, 3)];
      ra = {$urandom, $urandom};
      sel = $urandom_range(0, 3);
      rb = (sel == 0) ? 64'd0 : (sel == 1) ? 64'($urandom_range(1, 15)) : {$urandom, $urandom};
      run_op(s, f3, ra, rb, ref_mdu(f3, ra, rb, (s == 0) ? 64 : 8),
             $sformatf("rnd%0d/x%0d/f3_%0d/a%0h/b%0h", i, (s == 0) ? 64 : 8, f3, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_control_mdu.md
Name: alu_control_mdu

Overview:
- Parametrised successor to the single-cycle ALU control decoder.
- Decodes ALUOp plus an extended funct field (funct7[5], funct7[0], funct3) into a 4-bit ALU operation code.
- Also sequences unsigned RV M-extension ops (MUL, MULHU, DIVU, REMU) on an iterative radix-2 multiply/divide unit.
- Sits between main control and the datapath ALU; asserts stall to hold the PC while a multi-cycle op runs.

Parameters:
- XLEN, 64: operand/result width; legal range >= 4.
- ENABLE_M, 1: 1 = M ops sequenced; 0 = M ops flagged illegal and never started.
- CNT_W, $clog2(XLEN+1): derived localparam, iteration counter width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ALUOp  in  2  00 load/store, 01 branch, 10 R-type, 11 I-type arithmetic.
- Funct  in  5  {funct7[5], funct7[0], funct3}.
- op_valid  in  1  current instruction is valid; held stable by the datapath while stall=1.
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- Operation  out  4  ALU opcode, combinational.
- illegal  out  1  unsupported ALUOp/Funct combination, combinational.
- stall  out  1  hold PC and pipeline state.
- mdu_done  out  1  one-cycle pulse; mdu_result valid.
- mdu_result  out  XLEN  M-op result; held until the next op starts.

Behaviour:
- Decode is purely combinational over all inputs; no inferred latches; every path assigns Operation.
- ALUOp 00 -> 0010 (add).
- ALUOp 01 -> 0110 (sub).
- ALUOp 10, Funct[3]=0: 0_000 add 0010; 1_000 sub 0110; 0_111 and 0000; 0_110 or 0001; 0_100 xor 0011; 0_001 sll 0100; 0_101 srl 0101; 1_101 sra 0111; 0_010 slt 1000; 0_011 sltu 1001.
- ALUOp 11: funct3 selects as above, ignoring Funct[4] except 101, where Funct[4]=1 gives sra. funct3=000 is always add.
- Any other combination: Operation=0010 and illegal=1.
- ALUOp 10, Funct[3]=1 (M op):
  - funct3 000 MUL, 011 MULHU, 101 DIVU, 111 REMU.
  - Other funct3 values, or any M op with ENABLE_M=0: illegal=1, no start.
  - Operation=0010 for all M ops; the datapath uses mdu_result.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: op_valid and a legal M op -> latch a, b and the op kind; counter=0; go to BUSY. stall=1 combinationally in this same cycle.
  - BUSY: one iteration per cycle; stall=1; after XLEN iterations (counter==XLEN-1) go to DONE.
  - DONE: mdu_done=1, stall=0 (the instruction retires), mdu_result valid; go to IDLE unconditionally. op_valid is ignored in DONE (no restart).
- Latency: start cycle T, result at T+XLEN+1. The next M op can start at T+XLEN+2 (back-to-back).
- Multiply: shift-add into a 2*XLEN accumulator. MUL returns the low XLEN bits; MULHU returns the high XLEN bits.
- Divide: restoring division, XLEN iterations; quotient for DIVU, remainder for REMU.
- Divide by zero: quotient all-ones, remainder = a, same latency.
- Inputs a, b and Funct are not sampled after the start cycle.
- Reset (any state, including mid-BUSY):
  - Next state IDLE.
  - stall=0, mdu_done=0, mdu_result=0, counter=0, accumulators=0.
  - Outputs after reset are driven only by combinational decode.
- Non-M ops never touch the FSM. stall is 0 for them unless the FSM is BUSY.

Decomposition:
- Package alu_pkg:
  - 4-bit Operation encodings (ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU).
  - ALUOp encodings.
  - M funct3 constants.
  - FSM state enum.
- One sub-module, mdu_iter: operand latch, counter, shift-add/restoring datapath, with start/done handshake.
- The top level keeps the decode logic and the stall generation.

Test Plan:
- Decode sweep: every ALUOp x Funct (128 vectors) -> Operation/illegal match the table. Examples: ALUOp=10, Funct=10101 -> 0111; ALUOp=10, Funct=00001 -> 0100; ALUOp=11, Funct=10000 -> 0010.
- MUL, XLEN=64, a=7, b=6 -> stall high for cycles T..T+64; mdu_done pulse at T+65; mdu_result=42.
- MULHU, a=0xFFFF_FFFF_FFFF_FFFF, b=2 -> mdu_result=1. DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU a=0x1234, b=0 -> all-ones. REMU a=0x1234, b=0 -> 0x1234. Latency unchanged (65 cycles).
- Reset asserted at BUSY cycle 10 -> next cycle IDLE, stall=0, mdu_result=0. A fresh MUL 3*5 then returns 15 with full latency.
- Back-to-back: MUL then DIVU held on op_valid -> exactly one start per op; second start at T+66; no double mdu_done. Repeat at XLEN=8 and ENABLE_M=0: M ops give illegal=1 and stall never asserted.
